// File: rtl/fetch_unit.sv
// Instruction fetch unit: a PC register feeding a circular prefetch queue.
// Branch/jump redirects flush the queue and reload the PC.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rd,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fetch_unit: DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] r_pc;
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    entry_t          r_mem [DEPTH];

    logic            w_pop;
    logic            w_push;
    logic            w_not_full;
    logic [XLEN-1:0] w_redirect_aligned;
    logic [XLEN-1:0] w_reset_aligned;

    assign w_not_full         = (r_count < CW'(DEPTH));
    assign out_valid          = (r_count != '0);
    assign w_pop              = out_valid && out_ready;
    // A pop frees a slot in the same cycle, so a full queue still fetches.
    assign w_push             = !redirect_valid && (w_not_full || w_pop);
    assign w_redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_reset_aligned    = {RESET_PC[XLEN-1:2], 2'b00};

    assign imem_addr = r_pc;
    assign out_pc    = r_mem[r_head].pc;
    assign out_instr = r_mem[r_head].instr;
    assign count     = r_count;

    // PC, pointers and occupancy; a redirect overrides push and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= w_reset_aligned;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_pc    <= w_redirect_aligned;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + XLEN'(4);
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Queue storage is not reset; entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{pc: r_pc, instr: imem_rd};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomised checks for fetch_unit against hand-computed values
// and a small queue model.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    logic        reset_w;
    logic        redirect_valid_w;
    logic [31:0] redirect_pc_w;
    logic        out_ready_w;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_rd_w;
    logic        out_valid_w;
    logic [31:0] out_pc_w;
    logic [31:0] out_instr_w;
    logic [2:0]  count_w;

    int n_checks;
    int n_errors;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        case (a)
            32'h0000_0000: instr_of = 32'h0050_0093;
            32'h0000_0004: instr_of = 32'hFFE0_8113;
            32'h0000_0008: instr_of = 32'h00A1_0193;
            default:       instr_of = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign imem_rd   = instr_of(imem_addr);
    assign imem_rd_w = instr_of(imem_addr_w);

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .count          (count)
    );

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk            (clk),
        .reset          (reset_w),
        .imem_addr      (imem_addr_w),
        .imem_rd        (imem_rd_w),
        .redirect_valid (redirect_valid_w),
        .redirect_pc    (redirect_pc_w),
        .out_valid      (out_valid_w),
        .out_ready      (out_ready_w),
        .out_pc         (out_pc_w),
        .out_instr      (out_instr_w),
        .count          (count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one edge, then release just after it.
    task automatic do_reset(input logic rdy);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = rdy;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        n_checks++;
        if (count !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        n_checks++;
        if (imem_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_addr got %h want 00000000", imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_in [3];
        exp_pc[0] = 32'h0; exp_in[0] = 32'h0050_0093;
        exp_pc[1] = 32'h4; exp_in[1] = 32'hFFE0_8113;
        exp_pc[2] = 32'h8; exp_in[2] = 32'h00A1_0193;
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== exp_in[i]) begin
                n_errors++;
                $display("FAIL stream[%0d] got v=%b %h/%h want 1 %h/%h",
                         i, out_valid, out_pc, out_instr, exp_pc[i], exp_in[i]);
            end
            n_checks++;
            if (count !== 3'd1) begin
                n_errors++;
                $display("FAIL stream_count[%0d] got %0d want 1", i, count);
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (count !== 3'(i) || imem_addr !== 32'(4 * i) || out_pc !== 32'h0) begin
                n_errors++;
                $display("FAIL stall_fill[%0d] got cnt=%0d addr=%h pc=%h want %0d %h 0",
                         i, count, imem_addr, out_pc, i, 4 * i);
            end
        end
        tick();
        n_checks++;
        if (count !== 3'd4 || imem_addr !== 32'h10 || out_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL stall_hold got cnt=%0d addr=%h pc=%h want 4 00000010 0",
                     count, imem_addr, out_pc);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd4 || imem_addr !== 32'h14 || out_pc !== 32'h4) begin
            n_errors++;
            $display("FAIL full_pop_push got cnt=%0d addr=%h pc=%h want 4 00000014 4",
                     count, imem_addr, out_pc);
        end
    endtask

    task automatic test_redirect();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 32'h100) begin
            n_errors++;
            $display("FAIL redirect_flush got cnt=%0d v=%b addr=%h want 0 0 00000100",
                     count, out_valid, imem_addr);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== instr_of(32'h100)) begin
            n_errors++;
            $display("FAIL redirect_first got v=%b %h/%h want 1 00000100/%h",
                     out_valid, out_pc, out_instr, instr_of(32'h100));
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        tick();
        tick();
        tick();
        n_checks++;
        if (count !== 3'd3) begin
            n_errors++;
            $display("FAIL async_pre_count got %0d want 3", count);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL async_clear got cnt=%0d v=%b want 0 0", count, out_valid);
        end
        #1;
        reset = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || count !== 3'd1) begin
            n_errors++;
            $display("FAIL async_restart got v=%b pc=%h cnt=%0d want 1 0 1",
                     out_valid, out_pc, count);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        reset_w = 1'b0;
        tick();
        reset_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid_w !== 1'b1 || out_pc_w !== exp_pc[i] ||
                out_instr_w !== instr_of(exp_pc[i])) begin
                n_errors++;
                $display("FAIL wrap[%0d] got v=%b %h/%h want 1 %h/%h", i, out_valid_w,
                         out_pc_w, out_instr_w, exp_pc[i], instr_of(exp_pc[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] mq[$];
        logic [31:0] mpc;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        pop;
        int          errs_before;
        do_reset(1'b0);
        mpc = 32'h0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            rdy   = 1'($urandom_range(0, 1));
            redir = ($urandom_range(0, 9) == 0);
            rpc   = 32'($urandom_range(0, 255)) << 4 | 32'($urandom_range(0, 15));
            out_ready      = rdy;
            redirect_valid = redir;
            redirect_pc    = rpc;
            pop = (mq.size() != 0) && rdy;
            errs_before = n_errors;
            if (mq.size() != 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_pc !== mq[0] || out_instr !== instr_of(mq[0])) begin
                    n_errors++;
                    $display("FAIL rand_head[%0d] got v=%b %h/%h want 1 %h/%h", cyc,
                             out_valid, out_pc, out_instr, mq[0], instr_of(mq[0]));
                end
            end else begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rand_empty[%0d] got v=%b want 0", cyc, out_valid);
                end
            end
            tick();
            if (redir) begin
                mq.delete();
                mpc = {rpc[31:2], 2'b00};
            end else begin
                if (pop) void'(mq.pop_front());
                if (mq.size() < 4) begin
                    mq.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
            end
            n_checks++;
            if (count !== 3'(mq.size()) || count > 3'd4 || imem_addr !== mpc) begin
                n_errors++;
                $display("FAIL rand_state[%0d] got cnt=%0d addr=%h want %0d %h",
                         cyc, count, imem_addr, mq.size(), mpc);
            end
            if (n_errors > errs_before + 20) break;
        end
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        reset_w          = 1'b0;
        redirect_valid_w = 1'b0;
        redirect_pc_w    = '0;
        out_ready_w      = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_async_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address and instruction width in bits.
REQ-002 Parameter DEPTH, default 4, prefetch-queue entries; SHALL be a power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; 0 clears state immediately regardless of clk.
REQ-006 imem_addr  output  XLEN  instruction-memory address, combinationally equal to PC.
REQ-007 imem_rd  input  XLEN  instruction word, combinational read of imem_addr in the same cycle.
REQ-008 redirect_valid  input  1  branch/jump taken; replace PC and flush queue.
REQ-009 redirect_pc  input  XLEN  redirect target.
REQ-010 out_valid  output  1  queue head holds a valid instruction.
REQ-011 out_ready  input  1  consumer accepts head this cycle.
REQ-012 out_pc  output  XLEN  PC of queue head.
REQ-013 out_instr  output  XLEN  instruction word of queue head.
REQ-014 count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-015 PC register SHALL hold the next fetch address; imem_addr = PC with bits [1:0] always 0.
REQ-016 push = !redirect_valid && (count < DEPTH || pop); pop = out_valid && out_ready.
REQ-017 On push, {PC, imem_rd} SHALL be written at the tail and PC SHALL advance by 4, modulo 2^XLEN (wrap from 32'hFFFF_FFFC to 0).
REQ-018 With no push and no redirect, PC SHALL hold its value (stall).
REQ-019 out_valid = (count != 0); out_pc and out_instr SHALL come from the head entry; both SHALL be don't-care when out_valid=0.
REQ-020 Queue SHALL be a circular buffer with head and tail pointers that wrap modulo DEPTH.
REQ-021 Occupancy SHALL update as follows: push without pop, count+1; pop without push, count-1; both, count unchanged.
REQ-022 When full (count==DEPTH) with pop, push SHALL occur in the same cycle, giving 100% throughput.
REQ-023 When empty, the head SHALL NOT bypass the fetch; a fetched word appears on out_* one cycle after the fetch (latency 1).
REQ-024 redirect_valid SHALL take priority over all other activity: the queue empties (count=0, pointers reset), PC <= {redirect_pc[XLEN-1:2],2'b00}, and no push occurs that cycle.
REQ-025 A pop in the same cycle as a redirect SHALL complete for the consumer, but the entry SHALL be discarded with the flush.
REQ-026 The first post-redirect word SHALL be pushed in the cycle after the redirect and SHALL be visible on out_* the cycle after that.
REQ-027 The block SHALL keep no state other than PC, queue storage, head, tail and count.

Reset
REQ-028 While reset=0: PC=RESET_PC, count=0, head=tail=0, out_valid=0; queue storage need not be cleared.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries asynchronously.
REQ-030 After reset deasserts, the first push SHALL occur at the first rising edge, fetching RESET_PC.

Verification
REQ-031 Load imem[0..2] = 00500093, FFE08113, 00A10193; hold out_ready=1 after reset -> out_pc/out_instr = 0/00500093, 4/FFE08113, 8/00A10193 on consecutive cycles.
REQ-032 Hold out_ready=0 -> count rises to DEPTH (4) in 4 cycles; PC stalls at 0x10; out_pc stays 0; then raise out_ready for 1 cycle -> pop and push together, count stays 4, PC becomes 0x14.
REQ-033 Queue holds entries, out_ready=1, redirect_valid=1 with redirect_pc=0x103 -> next cycle count=0, out_valid=0, imem_addr=0x100; the following cycle out_pc=0x100.
REQ-034 RESET_PC=32'hFFFF_FFF8, out_ready=1 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
REQ-035 Assert reset low asynchronously between edges while count=3 -> out_valid and count drop to 0 immediately; after release the first output is RESET_PC.
REQ-036 Random out_ready and redirects checked against a reference model -> no lost, duplicated or reordered instructions, and count is never above DEPTH.
